// File: rtl/aes128_fast_sequencer_pkg.sv
// Shared types and widths for the aes128_fast load sequencer.
`timescale 1ns/1ps
package aes_seq_pkg;

    localparam int AES_BLK_W   = 128;
    localparam int CORE_HALF_W = 64;
    localparam int CYC_W       = 16;

    // Sequencer states; the encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        INIT      = 3'd0,
        IDLE      = 3'd1,
        LOAD_LO   = 3'd2,
        LOAD_HI   = 3'd3,
        START     = 3'd4,
        WAIT_CLR  = 3'd5,
        WAIT_DONE = 3'd6,
        RESP      = 3'd7
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (v == '1) ? v : v + CYC_W'(1);
    endfunction

endpackage

// File: rtl/aes128_fast_sequencer_if.sv
// 128-bit request/response port between the register block and the sequencer.
//
// Handshake: a request transfers on the rising clk edge where req_valid and
// req_ready are both high; a response transfers on the edge where resp_valid
// and resp_ready are both high. A valid, once raised, stays high with its
// payload stable until that transfer edge. Neither ready waits on valid.
`timescale 1ns/1ps
interface aes128_fast_sequencer_if;
    import aes_seq_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [AES_BLK_W-1:0] req_key;
    logic [AES_BLK_W-1:0] req_pt;
    logic                 req_mode;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [AES_BLK_W-1:0] resp_ct;
    logic                 resp_timeout;
    logic [CYC_W-1:0]     resp_cycles;

    // Register-file side.
    modport master (
        output req_valid, req_key, req_pt, req_mode, resp_ready,
        input  req_ready, resp_valid, resp_ct, resp_timeout, resp_cycles
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_key, req_pt, req_mode, resp_ready,
        output req_ready, resp_valid, resp_ct, resp_timeout, resp_cycles
    );

endinterface

// File: rtl/aes128_fast_sequencer.sv
// Drives the aes128_fast 64-bit load protocol from a 128-bit request port:
// core reset after power-up, low/high half loading, start pulse, done wait
// with timeout, result capture, and the scope trigger window.
`timescale 1ns/1ps
module aes128_fast_sequencer
    import aes_seq_pkg::*;
#(
    parameter int RST_CYCLES  = 4,
    parameter int LOAD_CYCLES = 2,
    parameter int HI_CYCLES   = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                   clk,
    input  logic                   reset_n,
    aes128_fast_sequencer_if.slave bus,
    output logic                   core_reset,
    output logic                   core_load,
    output logic                   core_start,
    output logic                   core_mode,
    output logic [CORE_HALF_W-1:0] core_key,
    output logic [CORE_HALF_W-1:0] core_data,
    input  logic [AES_BLK_W-1:0]   core_dout,
    input  logic                   core_done,
    output logic                   trigger,
    output state_t                 dbg_state
);

    // Last count value of each timed phase (a count of N occupies N cycles).
    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0] HI_LAST   = 16'(HI_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    state_t               state;
    logic [15:0]          phase_cnt;     // shared by INIT, LOAD_LO and LOAD_HI
    logic [15:0]          to_cnt;        // wait cycles used so far in this run
    logic [AES_BLK_W-1:0] key_q;
    logic [AES_BLK_W-1:0] pt_q;

    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic [AES_BLK_W-1:0] resp_ct_q;
    logic                 resp_timeout_q;
    logic [CYC_W-1:0]     resp_cycles_q;

    logic                 wait_expired;
    logic [CYC_W-1:0]     cyc_next;

    assign wait_expired = (to_cnt == TO_LAST);
    assign cyc_next     = sat_inc(resp_cycles_q);

    // Half select comes only from the latched copy, so req_* may change freely after acceptance.
    assign core_key  = core_load ? key_q[CORE_HALF_W-1:0] : key_q[AES_BLK_W-1:CORE_HALF_W];
    assign core_data = core_load ? pt_q[CORE_HALF_W-1:0]  : pt_q[AES_BLK_W-1:CORE_HALF_W];

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_ct      = resp_ct_q;
    assign bus.resp_timeout = resp_timeout_q;
    assign bus.resp_cycles  = resp_cycles_q;
    assign dbg_state        = state;

    // Sequencer FSM: state, counters and every registered output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= INIT;
            phase_cnt      <= '0;
            to_cnt         <= '0;
            key_q          <= '0;
            pt_q           <= '0;
            core_reset     <= 1'b1;
            core_load      <= 1'b0;
            core_start     <= 1'b0;
            core_mode      <= 1'b0;
            trigger        <= 1'b0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_ct_q      <= '0;
            resp_timeout_q <= 1'b0;
            resp_cycles_q  <= '0;
        end else begin
            // core_start is a one-cycle pulse unless re-armed below.
            core_start <= 1'b0;
            case (state)
                INIT: begin
                    core_reset <= 1'b1;
                    if (phase_cnt == RST_LAST) begin
                        phase_cnt   <= '0;
                        core_reset  <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        key_q       <= bus.req_key;
                        pt_q        <= bus.req_pt;
                        core_mode   <= bus.req_mode;
                        req_ready_q <= 1'b0;
                        core_load   <= 1'b1;
                        phase_cnt   <= '0;
                        state       <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (phase_cnt == LOAD_LAST) begin
                        core_load <= 1'b0;
                        phase_cnt <= '0;
                        state     <= LOAD_HI;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                LOAD_HI: begin
                    if (phase_cnt == HI_LAST) begin
                        phase_cnt      <= '0;
                        core_start     <= 1'b1;
                        trigger        <= 1'b1;
                        to_cnt         <= '0;
                        resp_cycles_q  <= '0;
                        resp_timeout_q <= 1'b0;
                        state          <= START;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                START: begin
                    state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    // Let a done level left over from the previous run fall first.
                    resp_cycles_q <= cyc_next;
                    if (wait_expired) begin
                        resp_ct_q      <= '0;
                        resp_timeout_q <= 1'b1;
                        resp_valid_q   <= 1'b1;
                        trigger        <= 1'b0;
                        state          <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                        if (!core_done) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    resp_cycles_q <= cyc_next;
                    if (core_done) begin
                        resp_ct_q      <= core_dout;
                        resp_timeout_q <= 1'b0;
                        resp_valid_q   <= 1'b1;
                        trigger        <= 1'b0;
                        state          <= RESP;
                    end else if (wait_expired) begin
                        resp_ct_q      <= '0;
                        resp_timeout_q <= 1'b1;
                        resp_valid_q   <= 1'b1;
                        trigger        <= 1'b0;
                        state          <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                RESP: begin
                    // After an abort the core is re-reset before taking new work.
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        if (resp_timeout_q) begin
                            core_reset <= 1'b1;
                            phase_cnt  <= '0;
                            state      <= INIT;
                        end else begin
                            req_ready_q <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    core_reset <= 1'b1;
                    phase_cnt  <= '0;
                    state      <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_fast_sequencer.sv
// Directed bench for aes128_fast_sequencer with a behavioural aes128_fast stand-in.
`timescale 1ns/1ps
module tb_aes128_fast_sequencer;
    import aes_seq_pkg::*;

    localparam int RST_CYCLES  = 4;
    localparam int LOAD_CYCLES = 2;
    localparam int HI_CYCLES   = 2;
    localparam int TIMEOUT     = 1023;
    localparam int CORE_LAT    = 10;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic         mode;
        logic [127:0] exp_ct;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    aes128_fast_sequencer_if bus ();

    logic         core_reset, core_load, core_start, core_mode, trigger;
    logic [63:0]  core_key, core_data;
    logic [127:0] core_dout;
    logic         core_done;
    state_t       dbg_state;

    aes128_fast_sequencer #(
        .RST_CYCLES (RST_CYCLES),
        .LOAD_CYCLES(LOAD_CYCLES),
        .HI_CYCLES  (HI_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .core_reset(core_reset),
        .core_load (core_load),
        .core_start(core_start),
        .core_mode (core_mode),
        .core_key  (core_key),
        .core_data (core_data),
        .core_dout (core_dout),
        .core_done (core_done),
        .trigger   (trigger),
        .dbg_state (dbg_state)
    );

    // Cipher stand-in: two known FIPS-197 answers, otherwise a fixed scramble.
    function automatic logic [127:0] model_core(input logic [127:0] k, input logic [127:0] p, input logic m);
        if (m && k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        if (m && k == APPB_KEY && p == APPB_PT) return APPB_CT;
        return {k[63:0], k[127:64]} ^ {p[119:0], p[127:120]} ^ (m ? 128'h0 : {4{32'ha5a55a5a}});
    endfunction

    // ---------------- core stand-in ----------------
    logic [63:0] k_lo, k_hi, d_lo, d_hi;
    logic        busy, m_q, stuck;
    int          lat;

    // Done stays high until one cycle after the next start (stale done), rises CORE_LAT edges after start.
    always @(posedge clk) begin
        if (core_reset) begin
            core_done <= 1'b0;
            core_dout <= '0;
            busy      <= 1'b0;
            lat       <= 0;
        end else begin
            if (core_load) begin
                k_lo <= core_key;
                d_lo <= core_data;
            end else if (!busy) begin
                k_hi <= core_key;
                d_hi <= core_data;
            end
            if (core_start) begin
                busy <= 1'b1;
                lat  <= 0;
                m_q  <= core_mode;
            end else if (busy) begin
                if (lat == 0) core_done <= 1'b0;
                if (lat == CORE_LAT - 1) begin
                    if (!stuck) begin
                        core_done <= 1'b1;
                        core_dout <= model_core({k_hi, k_lo}, {d_hi, d_lo}, m_q);
                        busy      <= 1'b0;
                    end
                end else begin
                    lat <= lat + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int n_applied    = 0;
    int n_miscompare = 0;
    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_applied++;
        n_miscompare++;
        $display("FAIL %s: actual no event within bound, required event", name);
    endtask

    // ---------------- driver tasks ----------------
    task automatic present(input vec_t v);
        bus.req_key  = v.key;
        bus.req_pt   = v.pt;
        bus.req_mode = v.mode;
    endtask

    task automatic scramble();
        bus.req_key  = {$urandom, $urandom, $urandom, $urandom};
        bus.req_pt   = {$urandom, $urandom, $urandom, $urandom};
        bus.req_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) timeout_fail("idle_wait");
    endtask

    task automatic wait_start();
        int n = 0;
        while (!core_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!core_start) timeout_fail("start_wait");
    endtask

    // Returns at the negedge right after the acceptance edge (first LOAD_LO cycle).
    task automatic send_req(input vec_t v);
        wait_idle();
        present(v);
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble();
    endtask

    task automatic get_resp(output logic [127:0] ct, output logic to, output logic [15:0] cyc,
                            output logic trig, output bit ok);
        int n = 0;
        while (!bus.resp_valid && n < TIMEOUT + 100) begin
            @(negedge clk);
            n++;
        end
        ok   = bus.resp_valid;
        ct   = bus.resp_ct;
        to   = bus.resp_timeout;
        cyc  = bus.resp_cycles;
        trig = trigger;
        if (!ok) begin
            timeout_fail("resp_wait");
        end else begin
            bus.resp_ready = 1'b1;
            @(negedge clk);
            bus.resp_ready = 1'b0;
        end
    endtask

    task automatic count_init(output int n);
        n = 0;
        while (core_reset && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_resp(input string tag);
        logic [127:0] ct;
        logic         to, trig;
        logic [15:0]  cyc;
        bit           ok;
        logic [127:0] exp;
        get_resp(ct, to, cyc, trig, ok);
        exp = exp_q.pop_front();
        if (ok) begin
            check({tag, "_ct"}, ct, exp);
            check({tag, "_timeout"}, to, 0);
            check({tag, "_cycles"}, cyc, CORE_LAT + 1);
            check({tag, "_trigger"}, trig, 0);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        send_req(v);
        exp_q.push_back(v.exp_ct);
        check_resp(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: actual still running, required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int   n, ready_cycles, consec, overlap, accepts, resps, bad;
        logic prev_ready, adv;
        logic [127:0] held;

        reset_n        = 1'b0;
        stuck          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_key    = '0;
        bus.req_pt     = '0;
        bus.req_mode   = 1'b0;
        bus.resp_ready = 1'b0;

        vecs[0] = '{FIPS_KEY, FIPS_PT, 1'b1, FIPS_CT};
        vecs[1] = '{FIPS_KEY, FIPS_PT, 1'b0, 128'h0};
        vecs[2] = '{APPB_KEY, APPB_PT, 1'b1, APPB_CT};
        vecs[3] = '{128'hdeadbeef_0badf00d_13579bdf_2468ace0, 128'hffffffff_00000000_12345678_9abcdef0, 1'b0, 128'h0};
        vecs[1].exp_ct = model_core(vecs[1].key, vecs[1].pt, vecs[1].mode);
        vecs[3].exp_ct = model_core(vecs[3].key, vecs[3].pt, vecs[3].mode);

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_core_reset", core_reset, 1);
        check("rst_ctl", {bus.req_ready, bus.resp_valid, core_load, core_start, core_mode, trigger, bus.resp_timeout}, 0);
        check("rst_halves", {core_key, core_data}, 0);
        check("rst_resp", {bus.resp_ct}, 0);
        check("rst_state", dbg_state, INIT);

        // Power-up core reset window.
        reset_n = 1'b1;
        count_init(n);
        check("init_cycles", n, RST_CYCLES);
        check("idle_ready", bus.req_ready, 1);

        // Half ordering and start latency on the FIPS vector.
        send_req(vecs[0]);
        exp_q.push_back(vecs[0].exp_ct);
        for (int i = 0; i < LOAD_CYCLES; i++) begin
            check($sformatf("lo_ctl_%0d", i), {core_load, core_start, bus.req_ready}, 3'b100);
            check($sformatf("lo_halves_%0d", i), {core_key, core_data}, {FIPS_KEY[63:0], FIPS_PT[63:0]});
            @(negedge clk);
        end
        for (int i = 0; i < HI_CYCLES; i++) begin
            check($sformatf("hi_ctl_%0d", i), {core_load, core_start}, 2'b00);
            check($sformatf("hi_halves_%0d", i), {core_key, core_data}, {FIPS_KEY[127:64], FIPS_PT[127:64]});
            @(negedge clk);
        end
        check("start_ctl", {core_load, core_start, trigger, core_mode}, 4'b0111);
        check("start_halves", {core_key, core_data}, {FIPS_KEY[127:64], FIPS_PT[127:64]});
        @(negedge clk);
        check("start_pulse_end", {core_start, trigger}, 2'b01);
        check_resp("fips");

        // Table of vectors.
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: req_valid and resp_ready held high for three runs.
        wait_idle();
        present(vecs[0]);
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        ready_cycles = 0; consec = 0; overlap = 0; accepts = 0; resps = 0;
        prev_ready = 1'b0;
        for (int c = 0; c < 800 && resps < 3; c++) begin
            if (bus.resp_valid) begin
                check($sformatf("b2b_ct_%0d", resps), bus.resp_ct, exp_q.pop_front());
                check($sformatf("b2b_cycles_%0d", resps), bus.resp_cycles, CORE_LAT + 1);
                if (bus.req_ready) overlap++;
                resps++;
            end
            adv = bus.req_ready;
            if (bus.req_ready) begin
                ready_cycles++;
                if (prev_ready) consec++;
                if (accepts < 4) exp_q.push_back(vecs[accepts].exp_ct);
                accepts++;
            end
            prev_ready = bus.req_ready;
            @(negedge clk);
            if (adv) begin
                if (accepts < 3) present(vecs[accepts]);
                else bus.req_valid = 1'b0;
            end
        end
        if (resps < 3) timeout_fail("b2b_resp");
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        exp_q.delete();
        check("b2b_ready_cycles", ready_cycles, 3);
        check("b2b_ready_single", consec, 0);
        check("b2b_no_accept_on_consume", overlap, 0);

        // Backpressure: response held 50 cycles while a competing request is offered.
        send_req(vecs[2]);
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        held = bus.resp_ct;
        present(vecs[3]);
        bus.req_valid = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_ct !== held || bus.req_ready) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_ct", held, vecs[2].exp_ct);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("bp_released", bus.resp_valid, 0);
        @(negedge clk);
        check("bp_ignored_req", bus.req_ready, 1);

        // Stuck core: abort after TIMEOUT wait cycles, then the core is reset again.
        stuck = 1'b1;
        send_req(vecs[3]);
        wait_start();
        n = 0;
        while (!bus.resp_valid && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", n, TIMEOUT + 1);
        check("to_flag", bus.resp_timeout, 1);
        check("to_ct", bus.resp_ct, 0);
        check("to_cycles", bus.resp_cycles, TIMEOUT);
        check("to_trigger", trigger, 0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        stuck = 1'b0;
        count_init(n);
        check("to_core_reset_cycles", n, RST_CYCLES);

        // Reset while waiting for done: immediate abort, no response, then a clean run.
        send_req(vecs[0]);
        wait_start();
        repeat (4) @(negedge clk);
        check("mid_state", dbg_state, WAIT_DONE);
        reset_n = 1'b0;
        #1;
        check("mid_rst_core_reset", core_reset, 1);
        check("mid_rst_ctl", {bus.req_ready, bus.resp_valid, core_load, core_start, core_mode, trigger, bus.resp_timeout}, 0);
        check("mid_rst_halves", {core_key, core_data}, 0);
        check("mid_rst_resp", {bus.resp_cycles, bus.resp_ct[111:0]}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        count_init(n);
        check("mid_init_cycles", n, RST_CYCLES);
        check("mid_no_resp", bus.resp_valid, 0);
        run_vec(vecs[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
